// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a FIFO with a valid/ready write port.
// The core pushes words back-to-back. The serialiser pops one word per frame
// and sends it LSB first, framed by one start bit and STOP_BITS stop bits.
// When the FIFO is non-empty at the end of a stop bit, the next frame follows
// without an idle gap.
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit after
// the data bits.
module uart_tx_fifo #(
  parameter  int CLK_HZ     = 24_000_000,
  parameter  int BAUD       = 115_200,
  parameter  int DATA_BITS  = 8,
  parameter  int STOP_BITS  = 1,
  parameter  int FIFO_DEPTH = 16,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 wr_valid,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 wr_ready,
  output logic [AW:0]          fifo_count,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 tx_busy,
  output logic                 tx
);

  // Clocks per bit, rounded to nearest; DIV >= 2 so CW >= 1 and DIV-1 fits.
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int BW  = 4;
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign wr_ready   = !fifo_full;
  assign fifo_count = count;
  // A full FIFO refuses writes even when a pop happens in the same cycle.
  assign push       = wr_valid && !fifo_full;
  assign head       = mem[rd_ptr];

  // Storage array: written on accepted pushes.
  // NOTE: the array has no reset; pointers and count define what is valid, and
  // leaving storage unreset lets it map onto plain RAM/flops without reset muxes.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at FIFO_DEPTH.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------- serialiser
  state_t               state, state_next;
  logic [CW-1:0]        baud, baud_next;
  logic [BW-1:0]        bit_cnt, bit_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 tx_next;
  logic                 baud_done;
`ifdef UART_TX_PARITY_EN
  logic                 par, par_next;
`endif

  assign baud_done = (baud == '0);
  assign tx_busy   = (state != S_IDLE);

  // Serialiser registers; tx is registered so the line never glitches.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_cnt <= bit_next;
      shift   <= shift_next;
      tx      <= tx_next;
`ifdef UART_TX_PARITY_EN
      par     <= par_next;
`endif
    end
  end

  // Next-state logic: the line level for the current state, bit timing and
  // the pop that starts each frame.
  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    baud_next  = baud;
    bit_next   = bit_cnt;
    shift_next = shift;
    tx_next    = 1'b1;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_next   = par;
`endif

    case (state)
      S_IDLE: begin
        pop = !fifo_empty;
      end
      S_START: begin
        tx_next = 1'b0;
        if (baud_done) begin
          state_next = S_DATA;
          baud_next  = DIV_M1;
          bit_next   = '0;
        end else begin
          baud_next = baud - CW'(1);
        end
      end
      S_DATA: begin
        tx_next = shift[0];
        if (baud_done) begin
          baud_next  = DIV_M1;
          shift_next = shift >> 1;
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            bit_next   = '0;
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end else begin
            bit_next = bit_cnt + BW'(1);
          end
        end else begin
          baud_next = baud - CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_next = par;
        if (baud_done) begin
          state_next = S_STOP;
          baud_next  = DIV_M1;
          bit_next   = '0;
        end else begin
          baud_next = baud - CW'(1);
        end
      end
`endif
      S_STOP: begin
        tx_next = 1'b1;
        if (baud_done) begin
          baud_next = DIV_M1;
          if (bit_cnt == BW'(STOP_BITS - 1)) begin
            bit_next   = '0;
            state_next = S_IDLE;
            pop        = !fifo_empty;
          end else begin
            bit_next = bit_cnt + BW'(1);
          end
        end else begin
          baud_next = baud - CW'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Any pop loads the head word and begins a new start bit.
    if (pop) begin
      state_next = S_START;
      baud_next  = DIV_M1;
      bit_next   = '0;
      shift_next = head;
`ifdef UART_TX_PARITY_EN
      par_next   = ^head;
`endif
    end
  end

endmodule
